// File: rtl/stopwatch_controller.sv
// Stopwatch control: debounced buttons, IDLE/RUN/PAUSE/LAP sequencing, count-enable prescaler.
// In: i_clk, i_reset, i_start_stop, i_lap, i_clear. Out: o_tick, o_clear, o_lap_capture, o_display_hold, o_running, o_state.
module stopwatch_controller #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned TICK_HZ         = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start_stop,
  input  logic       i_lap,
  input  logic       i_clear,
  output logic       o_tick,
  output logic       o_clear,
  output logic       o_lap_capture,
  output logic       o_display_hold,
  output logic       o_running,
  output logic [1:0] o_state
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DW  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // bit 0 start/stop, bit 1 lap, bit 2 clear
  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_deb;
  logic [2:0]    r_deb_d;
  logic [2:0]    r_press;
  logic [DW-1:0] r_db_cnt [3];

  assign w_raw = {i_clear, i_lap, i_start_stop};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_press <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_press <= r_deb & ~r_deb_d;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_MAX) begin
          // this is the DEBOUNCE_CYCLES-th differing cycle
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic w_p_ss;
  logic w_p_lap;
  logic w_p_clr;

  assign w_p_ss  = r_press[0];
  assign w_p_lap = r_press[1];
  assign w_p_clr = r_press[2];

  state_t        r_state;
  state_t        w_next;
  logic          w_clr;
  logic          w_cap;
  logic [PW-1:0] r_pre;

  // highest-priority press valid in the current state wins
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_cap  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_p_clr)     w_clr  = 1'b1;
        else if (w_p_ss) w_next = RUN;
      end
      RUN: begin
        if (w_p_ss) begin
          w_next = PAUSE;
        end else if (w_p_lap) begin
          w_next = LAP;
          w_cap  = 1'b1;
        end
      end
      LAP: begin
        if (w_p_clr)      w_next = RUN;
        else if (w_p_ss)  w_next = PAUSE;
        else if (w_p_lap) w_cap  = 1'b1;
      end
      PAUSE: begin
        if (w_p_clr) begin
          w_next = IDLE;
          w_clr  = 1'b1;
        end else if (w_p_ss) begin
          w_next = RUN;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  logic w_run_cur;
  logic w_run_nxt;
  logic w_wrap;

  assign w_run_cur = (r_state == RUN) || (r_state == LAP);
  assign w_run_nxt = (w_next == RUN) || (w_next == LAP);
  assign w_wrap    = (r_pre == PRE_MAX);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_pre          <= '0;
      o_tick         <= 1'b0;
      o_clear        <= 1'b0;
      o_lap_capture  <= 1'b0;
      o_display_hold <= 1'b0;
      o_running      <= 1'b0;
    end else begin
      r_state        <= w_next;
      o_clear        <= w_clr;
      o_lap_capture  <= w_cap;
      o_display_hold <= (w_next == LAP);
      o_running      <= w_run_nxt;
      // a tick due on the cycle we stop is withheld until resume
      o_tick         <= w_run_cur && w_run_nxt && w_wrap;
      if ((r_state == IDLE) || (w_next == IDLE)) begin
        r_pre <= '0;
      end else if (w_run_cur && !(w_wrap && !w_run_nxt)) begin
        r_pre <= w_wrap ? '0 : r_pre + PW'(1);
      end
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller (DIV=10, debounce 4).
// Drives buttons #1 after each edge and checks outputs there.
module tb_stopwatch_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss;
  logic       lap;
  logic       clr;
  logic       o_tick;
  logic       o_clear;
  logic       o_cap;
  logic       o_hold;
  logic       o_run;
  logic [1:0] o_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int tmode = 2;
  int tbase = 0;

  always #5 clk = ~clk;

  stopwatch_controller #(
    .CLK_HZ          (100),
    .TICK_HZ         (10),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_start_stop   (ss),
    .i_lap          (lap),
    .i_clear        (clr),
    .o_tick         (o_tick),
    .o_clear        (o_clear),
    .o_lap_capture  (o_cap),
    .o_display_hold (o_hold),
    .o_running      (o_run),
    .o_state        (o_state)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask

  // tmode 0: no tick allowed; 1: tick every 10 from tbase; 2: unchecked
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tmode == 0)
      chk("tick_off", 32'(o_tick), 32'd0);
    else if (tmode == 1)
      chk("tick_per", 32'(o_tick),
          32'((cyc >= tbase) && (((cyc - tbase) % 10) == 0)));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] outs();
    return 32'({o_tick, o_clear, o_cap, o_hold, o_run, o_state});
  endfunction

  initial begin
    rst = 1'b1;
    ss  = 1'b0;
    lap = 1'b0;
    clr = 1'b0;
    steps(2);
    chk("rst_outs", outs(), 32'd0);
    rst = 1'b0;
    steps(2);
    chk("idle", 32'(o_state), 32'd0);

    // S1: clean start press, periodic ticks
    tmode = 0;
    ss = 1'b1;
    steps(7);
    chk("s1_pre", 32'(o_state), 32'd0);
    step();
    chk("s1_run", 32'(o_state), 32'd1);
    chk("s1_running", 32'(o_run), 32'd1);
    tbase = cyc + 10;
    tmode = 1;
    steps(2);
    ss = 1'b0;
    steps(28);
    chk("s1_one_press", 32'(o_state), 32'd1);

    // S2: pause with prescaler at 5, resume 4 cycles to tick
    steps(8);
    ss = 1'b1;
    steps(7);
    chk("s2_still_run", 32'(o_state), 32'd1);
    tmode = 0;
    step();
    chk("s2_pause", 32'(o_state), 32'd2);
    chk("s2_run_lo", 32'(o_run), 32'd0);
    ss = 1'b0;
    steps(50);
    ss = 1'b1;
    steps(7);
    chk("s2_pre_res", 32'(o_state), 32'd2);
    step();
    chk("s2_resume", 32'(o_state), 32'd1);
    tbase = cyc + 4;
    tmode = 1;
    steps(2);
    ss = 1'b0;
    steps(10);

    // S4: lap, lap, clear while ticks continue
    lap = 1'b1;
    steps(7);
    chk("s4_pre_lap", 32'(o_state), 32'd1);
    chk("s4_pre_cap", 32'(o_cap), 32'd0);
    step();
    chk("s4_lap1", 32'(o_state), 32'd3);
    chk("s4_cap1", 32'(o_cap), 32'd1);
    chk("s4_hold1", 32'(o_hold), 32'd1);
    lap = 1'b0;
    step();
    chk("s4_cap1_off", 32'(o_cap), 32'd0);
    chk("s4_hold1b", 32'(o_hold), 32'd1);
    steps(10);
    lap = 1'b1;
    steps(8);
    chk("s4_lap2", 32'(o_state), 32'd3);
    chk("s4_cap2", 32'(o_cap), 32'd1);
    step();
    chk("s4_cap2_off", 32'(o_cap), 32'd0);
    lap = 1'b0;
    steps(10);
    clr = 1'b1;
    steps(8);
    chk("s4_back_run", 32'(o_state), 32'd1);
    chk("s4_hold_off", 32'(o_hold), 32'd0);
    chk("s4_no_clear", 32'(o_clear), 32'd0);
    clr = 1'b0;
    steps(10);
    clr = 1'b1;
    steps(8);
    chk("run_clr_ign", 32'(o_state), 32'd1);
    chk("run_clr_nop", 32'(o_clear), 32'd0);
    clr = 1'b0;
    steps(10);

    // stop exactly on a wrap cycle: tick withheld, fires after resume
    for (int w = 0; w < 10 && ((cyc + 8 - tbase) % 10) != 0; w++)
      step();
    ss = 1'b1;
    steps(7);
    tmode = 0;
    step();
    chk("sup_pause", 32'(o_state), 32'd2);
    ss = 1'b0;
    steps(12);
    ss = 1'b1;
    steps(8);
    chk("sup_resume", 32'(o_state), 32'd1);
    tmode = 2;
    step();
    chk("sup_tick", 32'(o_tick), 32'd1);
    tbase = cyc;
    tmode = 1;
    ss = 1'b0;
    steps(12);

    // back to PAUSE away from a wrap
    for (int w = 0; w < 10 && ((cyc + 8 - tbase) % 10) != 5; w++)
      step();
    ss = 1'b1;
    steps(8);
    chk("s5_pause", 32'(o_state), 32'd2);
    tmode = 0;
    ss = 1'b0;
    steps(12);

    // S5: clear and start together in PAUSE
    clr = 1'b1;
    ss  = 1'b1;
    steps(7);
    chk("s5_pre", 32'(o_state), 32'd2);
    step();
    chk("s5_idle", 32'(o_state), 32'd0);
    chk("s5_clear", 32'(o_clear), 32'd1);
    chk("s5_run_lo", 32'(o_run), 32'd0);
    step();
    chk("s5_clear_off", 32'(o_clear), 32'd0);
    chk("s5_idle2", 32'(o_state), 32'd0);
    clr = 1'b0;
    ss  = 1'b0;
    steps(12);
    chk("s5_ss_gone", 32'(o_state), 32'd0);

    lap = 1'b1;
    steps(8);
    chk("idle_lap_st", 32'(o_state), 32'd0);
    chk("idle_lap_cap", 32'(o_cap), 32'd0);
    lap = 1'b0;
    steps(10);
    clr = 1'b1;
    steps(8);
    chk("idle_clr", 32'(o_clear), 32'd1);
    chk("idle_clr_st", 32'(o_state), 32'd0);
    step();
    chk("idle_clr_off", 32'(o_clear), 32'd0);
    clr = 1'b0;
    steps(10);

    // S3: 2-cycle bounces, then stable high
    for (int b = 0; b < 2; b++) begin
      ss = 1'b1;
      steps(2);
      ss = 1'b0;
      steps(2);
    end
    steps(2);
    chk("s3_bounce", 32'(o_state), 32'd0);
    ss = 1'b1;
    steps(7);
    chk("s3_pre", 32'(o_state), 32'd0);
    step();
    chk("s3_run", 32'(o_state), 32'd1);
    tbase = cyc + 10;
    tmode = 1;
    steps(13);

    // S6: async reset between edges, start still held
    #3;
    rst = 1'b1;
    #1;
    chk("s6_async", outs(), 32'd0);
    tmode = 0;
    steps(2);
    rst = 1'b0;
    steps(7);
    chk("s6_pre", 32'(o_state), 32'd0);
    step();
    chk("s6_rerun", 32'(o_state), 32'd1);
    tbase = cyc + 10;
    tmode = 1;
    steps(11);
    ss = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
- Control FSM for the stopwatch digit chain. It turns three raw push-button levels (start/stop, lap, clear) into debounced single-cycle press events.
- It sequences the counter datapath through idle, run, pause and lap-hold modes.
- It generates the single 10 Hz count-enable tick on the 50 MHz clock. This replaces per-digit free-running dividers and the switch-driven reset.
- The tenths-of-seconds counter consumes o_tick as its enable. The digit chain and display registers consume o_clear, o_lap_capture and o_display_hold.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- TICK_HZ, 10, count-enable tick rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a synchronized button level is accepted (20 ms at 50 MHz). Must be ≥ 1.

Ports:
- i_clk, input, 1, system clock (MAX10_CLK1_50 at top level).
- i_reset, input, 1, asynchronous active-high reset.
- i_start_stop, input, 1, raw start/stop button level, active-high. The top level inverts KEY.
- i_lap, input, 1, raw lap button level, active-high.
- i_clear, input, 1, raw clear button level, active-high.
- o_tick, output, 1, one-cycle count enable at TICK_HZ while counting.
- o_clear, output, 1, one-cycle synchronous clear for all digit counters.
- o_lap_capture, output, 1, one-cycle pulse: display register loads current counter values.
- o_display_hold, output, 1, high while the display shows the captured lap value.
- o_running, output, 1, high in RUN or LAP.
- o_state, output, 2, current state encoding (LEDR debug).

Behaviour:
- Reset (async, i_reset=1):
  - State goes to IDLE. All outputs go to 0.
  - Synchronizers, debounced levels, debounce counters and the prescaler go to 0.
- Input path (per button, independent):
  - Two-flop synchronizer.
  - Debounce counter: counts consecutive cycles where the synchronized value differs from the debounced level. It resets to 0 on any cycle where they are equal.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - A press event is a one-cycle registered pulse on a 0→1 transition of the debounced level. Releases generate nothing.
  - A button held through reset release produces one press after debounce.
- Latency: a raw rising level first sampled at edge k gives a press pulse high in the cycle after edge k+2+DEBOUNCE_CYCLES (±1 edge allowed, fixed per build). The FSM reacts at the next edge.
- Press priority when several presses coincide: clear > start_stop > lap. Only the highest-priority press that is valid in the current state acts; the others are discarded.
- States (o_state encoding):
  - IDLE=00, RUN=01, PAUSE=10, LAP=11.
- Transitions:
  - IDLE:
    - start → RUN.
    - clear → o_clear pulse, stay in IDLE.
    - lap ignored.
  - RUN:
    - start → PAUSE.
    - lap → LAP, with o_lap_capture pulse.
    - clear ignored.
  - LAP: counters keep running while the display is frozen.
    - lap → LAP, with a new o_lap_capture pulse.
    - start → PAUSE. Hold is released.
    - clear → RUN. Hold is released. No o_clear.
  - PAUSE:
    - start → RUN.
    - clear → IDLE, with o_clear pulse.
    - lap ignored.
- Outputs are registered and take their new values at the same edge as the state update:
  - o_display_hold=1 exactly while in LAP.
  - o_running=1 in RUN and LAP.
  - o_clear and o_lap_capture are high for exactly one cycle.
- Prescaler (width $clog2(DIV)):
  - Increments only in RUN/LAP. Holds its value in PAUSE, so resume keeps the phase.
  - Is forced to 0 in IDLE and in any cycle where o_clear=1.
  - o_tick=1 in the cycle the prescaler equals DIV-1 while in RUN/LAP; the prescaler wraps to 0 on that cycle.
  - First tick after IDLE→RUN arrives DIV cycles after entering RUN.
  - A start press that leaves RUN on the same cycle the prescaler hits DIV-1 suppresses that tick. The prescaler then holds DIV-1, and the tick fires on the first RUN cycle after resume.
- Reset mid-operation: immediate return to IDLE. Any pending press or partial debounce is lost, and no o_clear is issued; reset clears the datapath directly.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=100, TICK_HZ=10 (DIV=10), DEBOUNCE_CYCLES=4.
- Scenario 1: reset, then hold start high 10 cycles → exactly one press, o_state 00→01, o_tick first high 10 cycles after entering RUN, then every 10 cycles.
- Scenario 2: in RUN with prescaler=5, press start, wait 50 cycles, press start → no o_tick while paused; the first tick after resume arrives 4 cycles into RUN.
- Scenario 3: bounce start 1,0,1,0 every 2 cycles, then stay high → a single press only after 4 stable cycles; bursts shorter than 4 cycles give no press.
- Scenario 4: RUN → lap → lap → clear → o_lap_capture pulses twice, o_display_hold 1 then 0, state 01→11→11→01, o_tick uninterrupted.
- Scenario 5: PAUSE with clear and start pressed in the same debounced cycle → clear wins: state 00, o_clear one cycle, prescaler 0, start discarded.
- Scenario 6: assert i_reset asynchronously mid-RUN between clock edges → all outputs 0 and o_state=00 before the next edge. After release with start still held → RUN is re-entered after debounce latency.
